// File: rtl/m_control.sv
// Sequencing controller for the RV32M multiply/divide datapath: drives the R/D/Z/mult selects per cycle.
// Optional macro M_DIV_ZERO_FASTPATH_EN: divide by zero skips the iteration loop and forces an all-ones quotient.
module m_control #(
    parameter int MUL_LATENCY      = 2,
    parameter int DIV_STEPS        = 32,
    parameter int MUX_R_LENGTH     = 3,
    parameter int MUX_D_LENGTH     = 2,
    parameter int MUX_Z_LENGTH     = 2,
    parameter int MUX_MULTA_LENGTH = 2,
    parameter int MUX_MULTB_LENGTH = 2
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        start,
    input  logic                        flush,
    input  logic [2:0]                  funct3,
    input  logic                        rs1_sign,
    input  logic                        rs2_sign,
    input  logic                        rs2_zero,
    input  logic                        sub_neg,
    output logic                        busy,
    output logic                        done,
    output logic                        res_sel_r,
    output logic                        res_negate,
    output logic                        quot_force_ones,
    output logic [MUX_R_LENGTH-1:0]     mux_R,
    output logic [MUX_D_LENGTH-1:0]     mux_D,
    output logic [MUX_Z_LENGTH-1:0]     mux_Z,
    output logic [MUX_MULTA_LENGTH-1:0] mux_multA,
    output logic [MUX_MULTB_LENGTH-1:0] mux_multB
);

    localparam logic [MUX_R_LENGTH-1:0] R_KEEP       = MUX_R_LENGTH'(0);
    localparam logic [MUX_R_LENGTH-1:0] R_A          = MUX_R_LENGTH'(1);
    localparam logic [MUX_R_LENGTH-1:0] R_A_NEG      = MUX_R_LENGTH'(2);
    localparam logic [MUX_R_LENGTH-1:0] R_SUB_KEEP   = MUX_R_LENGTH'(3);
    localparam logic [MUX_R_LENGTH-1:0] R_MULT_LOWER = MUX_R_LENGTH'(4);

    localparam logic [MUX_D_LENGTH-1:0] D_KEEP  = MUX_D_LENGTH'(0);
    localparam logic [MUX_D_LENGTH-1:0] D_B     = MUX_D_LENGTH'(1);
    localparam logic [MUX_D_LENGTH-1:0] D_B_NEG = MUX_D_LENGTH'(2);
    localparam logic [MUX_D_LENGTH-1:0] D_SHR   = MUX_D_LENGTH'(3);

    localparam logic [MUX_Z_LENGTH-1:0] Z_KEEP       = MUX_Z_LENGTH'(0);
    localparam logic [MUX_Z_LENGTH-1:0] Z_ZERO       = MUX_Z_LENGTH'(1);
    localparam logic [MUX_Z_LENGTH-1:0] Z_SHL_ADD    = MUX_Z_LENGTH'(2);
    localparam logic [MUX_Z_LENGTH-1:0] Z_MULT_UPPER = MUX_Z_LENGTH'(3);

    localparam logic [MUX_MULTA_LENGTH-1:0] MA_ZERO       = MUX_MULTA_LENGTH'(0);
    localparam logic [MUX_MULTA_LENGTH-1:0] MA_R_UNSIGNED = MUX_MULTA_LENGTH'(1);
    localparam logic [MUX_MULTA_LENGTH-1:0] MA_R_SIGNED   = MUX_MULTA_LENGTH'(2);

    localparam logic [MUX_MULTB_LENGTH-1:0] MB_ZERO       = MUX_MULTB_LENGTH'(0);
    localparam logic [MUX_MULTB_LENGTH-1:0] MB_D_UNSIGNED = MUX_MULTB_LENGTH'(1);
    localparam logic [MUX_MULTB_LENGTH-1:0] MB_D_SIGNED   = MUX_MULTB_LENGTH'(2);

    localparam int CNT_MAX = (DIV_STEPS > MUL_LATENCY) ? DIV_STEPS : MUL_LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, MUL_OPS, MUL_WAIT, MUL_WB, DIV_ITER, DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [2:0]       op_funct3;
    logic             op_rs1_sign;
    logic             op_rs2_sign;
    logic             op_rs2_zero;

    // The subtractor sign steers the datapath directly; the sequence never branches on it.
    logic unused_sub_neg;
    assign unused_sub_neg = sub_neg;

    logic in_signed_div;
    logic op_is_div;
    logic op_a_signed;
    logic op_b_signed;
    logic fin_sel_r;
    logic fin_negate;
    logic fin_force_ones;

    assign in_signed_div = funct3[2] & ~funct3[0];
    assign op_is_div     = op_funct3[2];
    assign op_a_signed   = (op_funct3 == 3'b001) | (op_funct3 == 3'b010);
    assign op_b_signed   = (op_funct3 == 3'b001);
    assign fin_sel_r     = (op_funct3 == 3'b000) | (op_funct3[2] & op_funct3[1]);
    assign fin_negate    = ~op_rs2_zero & (((op_funct3 == 3'b100) & (op_rs1_sign ^ op_rs2_sign)) |
                                           ((op_funct3 == 3'b110) & op_rs1_sign));
`ifdef M_DIV_ZERO_FASTPATH_EN
    assign fin_force_ones = op_is_div & op_rs2_zero & ~op_funct3[1];
`else
    assign fin_force_ones = 1'b0;
`endif

    // Outputs are registered alongside the state: each branch loads the values for the state being entered.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state           <= IDLE;
            count           <= '0;
            op_funct3       <= '0;
            op_rs1_sign     <= 1'b0;
            op_rs2_sign     <= 1'b0;
            op_rs2_zero     <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            res_sel_r       <= 1'b0;
            res_negate      <= 1'b0;
            quot_force_ones <= 1'b0;
            mux_R           <= R_KEEP;
            mux_D           <= D_KEEP;
            mux_Z           <= Z_KEEP;
            mux_multA       <= MA_ZERO;
            mux_multB       <= MB_ZERO;
        end else begin
            busy            <= 1'b0;
            done            <= 1'b0;
            res_sel_r       <= 1'b0;
            res_negate      <= 1'b0;
            quot_force_ones <= 1'b0;
            mux_R           <= R_KEEP;
            mux_D           <= D_KEEP;
            mux_Z           <= Z_KEEP;
            mux_multA       <= MA_ZERO;
            mux_multB       <= MB_ZERO;
            if (flush) begin
                state <= IDLE;
                count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        count <= '0;
                        if (start) begin
                            state       <= LOAD;
                            busy        <= 1'b1;
                            op_funct3   <= funct3;
                            op_rs1_sign <= rs1_sign;
                            op_rs2_sign <= rs2_sign;
                            op_rs2_zero <= rs2_zero;
                            mux_R <= (funct3[2] && in_signed_div && rs1_sign && !rs2_zero) ? R_A_NEG : R_A;
                            mux_D <= (funct3[2] && in_signed_div && rs2_sign) ? D_B_NEG : D_B;
                            mux_Z <= funct3[2] ? Z_ZERO : Z_KEEP;
                        end
                    end
                    LOAD: begin
                        busy  <= 1'b1;
                        count <= '0;
`ifdef M_DIV_ZERO_FASTPATH_EN
                        if (op_is_div && op_rs2_zero) begin
                            state           <= DONE;
                            done            <= 1'b1;
                            res_sel_r       <= fin_sel_r;
                            res_negate      <= fin_negate;
                            quot_force_ones <= fin_force_ones;
                        end else
`endif
                        if (op_is_div) begin
                            state <= DIV_ITER;
                            mux_R <= R_SUB_KEEP;
                            mux_D <= D_SHR;
                            mux_Z <= Z_SHL_ADD;
                        end else begin
                            state     <= MUL_OPS;
                            mux_multA <= op_a_signed ? MA_R_SIGNED : MA_R_UNSIGNED;
                            mux_multB <= op_b_signed ? MB_D_SIGNED : MB_D_UNSIGNED;
                        end
                    end
                    MUL_OPS: begin
                        busy      <= 1'b1;
                        state     <= MUL_WAIT;
                        count     <= '0;
                        mux_multA <= mux_multA;
                        mux_multB <= mux_multB;
                    end
                    MUL_WAIT: begin
                        busy      <= 1'b1;
                        mux_multA <= mux_multA;
                        mux_multB <= mux_multB;
                        if (count == CNT_W'(MUL_LATENCY - 1)) begin
                            state <= MUL_WB;
                            count <= '0;
                            mux_R <= R_MULT_LOWER;
                            mux_Z <= Z_MULT_UPPER;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    MUL_WB: begin
                        busy            <= 1'b1;
                        state           <= DONE;
                        done            <= 1'b1;
                        res_sel_r       <= fin_sel_r;
                        res_negate      <= fin_negate;
                        quot_force_ones <= fin_force_ones;
                    end
                    DIV_ITER: begin
                        busy <= 1'b1;
                        if (count == CNT_W'(DIV_STEPS - 1)) begin
                            state           <= DONE;
                            count           <= '0;
                            done            <= 1'b1;
                            res_sel_r       <= fin_sel_r;
                            res_negate      <= fin_negate;
                            quot_force_ones <= fin_force_ones;
                        end else begin
                            count <= count + 1'b1;
                            mux_R <= R_SUB_KEEP;
                            mux_D <= D_SHR;
                            mux_Z <= Z_SHL_ADD;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        count <= '0;
                    end
                    default: begin
                        state <= IDLE;
                        count <= '0;
                    end
                endcase
            end
        end
    end

endmodule
